rx_pkt_fifo: RTL
================

# rx_pkt_fifo

Store-and-forward packet FIFO that sits directly upstream of `seaccow_internal` and drives its `in` port. It accepts an Avalon-ST word stream from the MAC receive path, which cannot be back-pressured. Only complete, error-free packets that fit in the buffer are released downstream. Truncated, errored or oversized packets are discarded whole, so the analysis core only ever sees well-formed sop…eop frames.

## Interface
Parameters:
- `DEPTH`, 512: buffer size in words; power of two, ≥ 4.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `sys_clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in`  in  `avln_st`  MAC receive word; `valid`, `sop`, `eop`, `empty`, `data`; no ready.
- `in_error`  in  1  frame error (FCS/PHY); sampled only on the `eop` beat.
- `out`  out  `avln_st`  packet stream to `seaccow_internal`.
- `out_ready`  in  1  downstream accept; a beat transfers when `out.valid && out_ready`.
- `pkt_count`  out  `CNT_W`  packets committed; saturating.
- `drop_count`  out  `CNT_W`  packets dropped; saturating.
- `overflow`  out  1  one-cycle pulse per dropped packet.

## Operation
- Storage: `DEPTH` entries of {`data`, `empty`, `sop`, `eop`}.
- Pointers: `wr_ptr`, `commit_ptr` and `rd_ptr`, each `$clog2(DEPTH)+1` bits, wrapping modulo 2·`DEPTH`.
- Fill level: `wr_ptr - rd_ptr`. The buffer is full when the fill level equals `DEPTH`.
- Write FSM, IDLE / PKT / DISCARD:
  - IDLE, on valid && sop: write the word and go to PKT. If the same word also carries `eop`, it is a one-word packet: commit or drop it immediately and stay in IDLE.
  - IDLE, on valid && !sop: discard the orphan word; no count.
  - PKT, on valid && !sop && !eop: write the word. If the buffer is full, set `wr_ptr <= commit_ptr`, count a drop and go to DISCARD.
  - PKT, on valid && eop: if not full and `in_error` is 0, write the word, set `commit_ptr <= wr_ptr+1`, increment `pkt_count` and go to IDLE. Otherwise rewind `wr_ptr`, count a drop and go to IDLE.
  - PKT, on valid && sop (missing eop): rewind, count a drop, then treat the word as a fresh sop in the same cycle and stay in PKT.
  - DISCARD: ignore words until `eop`, then go to IDLE. A `sop` seen in DISCARD starts a new packet and goes to PKT.
- Read side: data is available when `rd_ptr != commit_ptr`. Uncommitted words are never visible downstream.
- Output: registered `out`, with a prefetch/skid stage so that one beat per cycle is sustained while `out_ready` is held high.
- `out` fields are held stable while `out.valid && !out_ready`.
- `out.empty` and `out.sop`/`out.eop` are replayed exactly as stored.
- Counters saturate at 2^`CNT_W`−1 and never wrap.

## Timing
- Reset (async assert, sync deassert by the surrounding logic): all pointers 0, FSM IDLE, `out.valid`=0, `out.sop`/`eop`/`empty`/`data`=0, both counters 0, `overflow`=0.
- Reset mid-packet discards every stored and partially written word.
- Latency: `eop` sampled at edge E, then `commit_ptr` updates at E, then the RAM read is issued at E+1, then `out.valid`=1 after edge E+2 with the packet's sop word.
- `overflow` and the count updates occur at the edge where the drop decision is made.
- A simultaneous read and write is always legal. Full is evaluated with the pre-edge `rd_ptr`, so a pop in the same cycle does not rescue a write.
- A packet longer than `DEPTH` words is always dropped.
- A packet of exactly `DEPTH` words commits only if the buffer was empty at its sop.

## Structure
- `global_types` package:
  - `avln_st` already lives here; no field changes.
  - Add `localparam` `AVLN_DATA_W` if absent.
  - Add `typedef enum` `rxf_state_t` {IDLE, PKT, DISCARD}.
- Sub-module `sdp_ram`: a simple dual-port RAM (one write port, one registered read port, parameterised width and depth). It is inferred as block RAM.
- The FSM, pointers, output skid and counters stay in `rx_pkt_fifo`.

## Test plan
Use `DEPTH`=16 and a 32-bit data path.
- Single 4-word packet (data 0x11..0x44, `empty`=2 on `eop`), `out_ready`=1 → identical 4 beats out, `out.valid` first high 2 cycles after `eop`. Result: `pkt_count`=1, `drop_count`=0.
- 20-word packet into an empty buffer → no output, `overflow` pulses once on word 17, `drop_count`=1. A following 3-word packet passes intact.
- 5-word packet with `in_error`=1 on `eop` → no output, `drop_count`=1, `wr_ptr` equals `commit_ptr`.
- `sop` at word 3 of a 6-word packet, no intervening `eop` → the first fragment is dropped (`drop_count`=1). The second packet, starting at that `sop`, is delivered complete.
- Back-to-back 8-word packets with `out_ready` toggling 1010… → all beats are delivered in order, each held stable while stalled, with no loss until the buffer is full. A packet arriving when the fill level is 12 is dropped.
- Assert `reset_n`=0 mid-output → `out.valid`=0 immediately and both counters read 0. The first packet after reset is delivered normally.

Source files
------------

// File: rtl/global_types.sv
// Shared types for the packet receive path.
//   avln_st      : Avalon-ST beat (valid, sop, eop, empty, data); no ready field.
//   rxf_state_t  : rx_pkt_fifo write-side state.
//   rxf_entry_t  : one stored word of rx_pkt_fifo (framing + payload).
package global_types;

  localparam int unsigned AVLN_DATA_W  = 32;
  localparam int unsigned AVLN_EMPTY_W = $clog2(AVLN_DATA_W / 8);

  typedef struct packed {
    logic                    valid;
    logic                    sop;
    logic                    eop;
    logic [AVLN_EMPTY_W-1:0] empty;
    logic [AVLN_DATA_W-1:0]  data;
  } avln_st;

  typedef enum logic [1:0] {
    IDLE,
    PKT,
    DISCARD
  } rxf_state_t;

  typedef struct packed {
    logic                    sop;
    logic                    eop;
    logic [AVLN_EMPTY_W-1:0] empty;
    logic [AVLN_DATA_W-1:0]  data;
  } rxf_entry_t;

endpackage

// File: rtl/rx_pkt_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read request; rdata_o updates on the edge after re_i
//   rdata_o          : registered read data
// No reset on storage or read register so it maps onto block RAM.
module sdp_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rx_pkt_fifo.sv
// Store-and-forward packet FIFO between the MAC receive path and the
// analysis core. Only complete, error-free packets that fit are released;
// truncated, errored or oversized packets are discarded whole.
//   sys_clk, reset_n : clock, asynchronous active-low reset
//   in, in_error     : MAC word stream (no back-pressure); error valid on eop
//   out, out_ready   : packet stream downstream, beat moves on valid && ready
//   pkt_count        : committed packets (saturating)
//   drop_count       : dropped packets (saturating)
//   overflow         : one-cycle pulse per dropped packet
module rx_pkt_fifo
  import global_types::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  avln_st           in,
  input  logic             in_error,
  output avln_st           out,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t PTR_ONE   = ptr_t'(1);
  localparam ptr_t PTR_DEPTH = ptr_t'(DEPTH);

  rxf_state_t       state_q, state_d;
  ptr_t             wr_q, wr_d;
  ptr_t             commit_q, commit_d;
  ptr_t             rd_q, rd_d;
  logic             ram_vld_q;
  avln_st           out_q, out_d;
  avln_st           skid_q, skid_d;
  logic [CNT_W-1:0] pkt_q, drop_q;
  logic             ovf_q;

  logic             full;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  rxf_entry_t       wr_entry;
  logic             commit_ev, drop_ev;
  logic             start, start_full;
  ptr_t             start_base;

  logic             rd_en, pop;
  logic [2:0]       inflight;
  rxf_entry_t       rd_entry;
  avln_st           ram_word;

  // ---------------- write side ----------------
  assign full = ptr_t'(wr_q - rd_q) == PTR_DEPTH;

  always_comb begin
    wr_entry.sop   = in.sop;
    wr_entry.eop   = in.eop;
    wr_entry.empty = in.empty;
    wr_entry.data  = in.data;
  end

  // A sop always goes through the shared "start" path; in PKT it first
  // rewinds to commit_ptr so the new packet overwrites the dropped fragment.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    commit_d   = commit_q;
    wr_en      = 1'b0;
    wr_addr    = wr_q[AW-1:0];
    commit_ev  = 1'b0;
    drop_ev    = 1'b0;
    start      = 1'b0;
    start_base = wr_q;
    start_full = 1'b0;
    if (in.valid) begin
      case (state_q)
        IDLE: start = in.sop;
        PKT: begin
          if (in.sop) begin
            drop_ev    = 1'b1;
            start      = 1'b1;
            start_base = commit_q;
          end else if (in.eop) begin
            state_d = IDLE;
            if (!full && !in_error) begin
              wr_en     = 1'b1;
              wr_d      = wr_q + PTR_ONE;
              commit_d  = wr_q + PTR_ONE;
              commit_ev = 1'b1;
            end else begin
              drop_ev = 1'b1;
              wr_d    = commit_q;
            end
          end else if (full) begin
            drop_ev = 1'b1;
            wr_d    = commit_q;
            state_d = DISCARD;
          end else begin
            wr_en = 1'b1;
            wr_d  = wr_q + PTR_ONE;
          end
        end
        DISCARD: begin
          if (in.sop) begin
            start = 1'b1;
          end else if (in.eop) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (start) begin
        start_full = ptr_t'(start_base - rd_q) == PTR_DEPTH;
        wr_addr    = start_base[AW-1:0];
        if (start_full) begin
          drop_ev = 1'b1;
          wr_d    = start_base;
          state_d = in.eop ? IDLE : DISCARD;
        end else if (in.eop && in_error) begin
          drop_ev = 1'b1;
          wr_d    = start_base;
          state_d = IDLE;
        end else begin
          wr_en = 1'b1;
          wr_d  = start_base + PTR_ONE;
          if (in.eop) begin
            commit_d  = start_base + PTR_ONE;
            commit_ev = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = PKT;
          end
        end
      end
    end
  end

  sdp_ram #(
    .WIDTH ($bits(rxf_entry_t)),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (sys_clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_entry),
    .re_i    (rd_en),
    .raddr_i (rd_q[AW-1:0]),
    .rdata_o (rd_entry)
  );

  // ---------------- read side ----------------
  // out_q and skid_q form a two-entry output queue. A read is issued only
  // when, after this edge, the queue plus the in-flight RAM word leave room
  // for one more word even if downstream stalls next cycle.
  always_comb begin
    pop      = out_q.valid && out_ready;
    inflight = 3'(out_q.valid) + 3'(skid_q.valid) + 3'(ram_vld_q) - 3'(pop);
    rd_en    = (rd_q != commit_q) && (inflight <= 3'd1);
    rd_d     = rd_en ? rd_q + PTR_ONE : rd_q;
  end

  always_comb begin
    ram_word.valid = ram_vld_q;
    ram_word.sop   = rd_entry.sop;
    ram_word.eop   = rd_entry.eop;
    ram_word.empty = rd_entry.empty;
    ram_word.data  = rd_entry.data;
  end

  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    if (pop || !out_q.valid) begin
      if (skid_q.valid) begin
        out_d        = skid_q;
        skid_d.valid = 1'b0;
        if (ram_vld_q) begin
          skid_d = ram_word;
        end
      end else if (ram_vld_q) begin
        out_d = ram_word;
      end else begin
        out_d.valid = 1'b0;
      end
    end else if (ram_vld_q) begin
      skid_d = ram_word;
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      commit_q  <= '0;
      rd_q      <= '0;
      ram_vld_q <= 1'b0;
      out_q     <= '0;
      skid_q    <= '0;
      pkt_q     <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      commit_q  <= commit_d;
      rd_q      <= rd_d;
      ram_vld_q <= rd_en;
      out_q     <= out_d;
      skid_q    <= skid_d;
      ovf_q     <= drop_ev;
      if (commit_ev && (pkt_q != '1)) begin
        pkt_q <= pkt_q + CNT_W'(1);
      end
      if (drop_ev && (drop_q != '1)) begin
        drop_q <= drop_q + CNT_W'(1);
      end
    end
  end

  assign out        = out_q;
  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule
